alu_csel_pipe: RTL and testbench

Parametrised, two-stage pipelined carry-select ALU with valid/ready handshakes on input and output. It generalises the fixed 32-bit, 16/16 carry-select ALU to any width split into equal segments. Every segment computes both carry-in candidates in stage 1, and the select chain resolves in stage 2. It sits between the register-file read stage and writeback, and can stall under downstream backpressure.

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_seg.sv | 24 ++
 rtl/alu_csel_pipe.sv | 148 ++++++++++++++
 tb/tb_alu_csel_pipe.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - operation encodings and stage-1 control payload for the carry-select ALU
package alu_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SLT = 2'b11;

    // Width-independent part of the S1 payload; the per-segment candidates live beside it.
    typedef struct packed {
        logic [1:0] op;
        logic       ovf0;
        logic       ovf1;
    } s1_ctrl_t;

endpackage

// File: rtl/alu_seg.sv
// rtl/alu_seg.sv - one carry-select segment: sum, logic result, carry out and MSB carry-in
module alu_seg
    import alu_pkg::*;
#(
    parameter int SEG_W = 16
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             cin,
    input  logic [1:0]       Operation,
    output logic [SEG_W-1:0] sum,
    output logic [SEG_W-1:0] logic_res,
    output logic             cout,
    output logic             msb_cin
);

    always_comb begin
        {cout, sum} = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, cin};
        // Carry into the MSB is recovered from the MSB sum bit.
        msb_cin     = a[SEG_W-1] ^ b[SEG_W-1] ^ sum[SEG_W-1];
        logic_res   = (Operation == OP_OR) ? (a | b) : (a & b);
    end

endmodule

// File: rtl/alu_csel_pipe.sv
// rtl/alu_csel_pipe.sv - two-stage pipelined carry-select ALU with valid/ready on both sides
module alu_csel_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SEG_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic             Ainvert,
    input  logic             Binvert,
    input  logic             carry_in,
    input  logic [1:0]       Operation,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int NSEG = WIDTH / SEG_W;

    logic [WIDTH-1:0] a, b;
    logic [NSEG-1:0][SEG_W-1:0] sum0_w, sum1_w, lr0_w, lr1_w;
    logic [NSEG-1:0] cout0_w, cout1_w, mc0_w, mc1_w;
    logic unused_seg;

    assign a = operandA ^ {WIDTH{Ainvert}};
    assign b = operandB ^ {WIDTH{Binvert}};

    generate
        for (genvar k = 0; k < NSEG; k++) begin : g_seg
            if (k == 0) begin : g_lo
                alu_seg #(.SEG_W(SEG_W)) u_seg (
                    .a(a[SEG_W-1:0]), .b(b[SEG_W-1:0]), .cin(carry_in), .Operation(Operation),
                    .sum(sum0_w[0]), .logic_res(lr0_w[0]), .cout(cout0_w[0]), .msb_cin(mc0_w[0])
                );
                // Segment 0 knows its real carry, so both candidates are the same.
                assign sum1_w[0]  = sum0_w[0];
                assign lr1_w[0]   = lr0_w[0];
                assign cout1_w[0] = cout0_w[0];
                assign mc1_w[0]   = mc0_w[0];
            end else begin : g_hi
                alu_seg #(.SEG_W(SEG_W)) u_c0 (
                    .a(a[k*SEG_W +: SEG_W]), .b(b[k*SEG_W +: SEG_W]), .cin(1'b0), .Operation(Operation),
                    .sum(sum0_w[k]), .logic_res(lr0_w[k]), .cout(cout0_w[k]), .msb_cin(mc0_w[k])
                );
                alu_seg #(.SEG_W(SEG_W)) u_c1 (
                    .a(a[k*SEG_W +: SEG_W]), .b(b[k*SEG_W +: SEG_W]), .cin(1'b1), .Operation(Operation),
                    .sum(sum1_w[k]), .logic_res(lr1_w[k]), .cout(cout1_w[k]), .msb_cin(mc1_w[k])
                );
            end
        end
    endgenerate

    assign unused_seg = ^{lr1_w, mc0_w, mc1_w};

    s1_ctrl_t                   s1_ctrl;
    logic                       s1_valid;
    logic [NSEG-1:0][SEG_W-1:0] s1_sum0, s1_sum1;
    logic [NSEG-1:0]            s1_cout0, s1_cout1;
    logic [WIDTH-1:0]           s1_logic;

    logic s2_adv;
    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_adv;

    logic [NSEG-1:0][SEG_W-1:0] sum_sel;
    logic                       sel, ovf_sel;
    logic [WIDTH-1:0]           res;
    logic                       res_c, res_v;

    always_comb begin
        sel     = 1'b0;
        ovf_sel = 1'b0;
        sum_sel = '0;
        for (int k = 0; k < NSEG; k++) begin
            sum_sel[k] = sel ? s1_sum1[k] : s1_sum0[k];
            if (k == NSEG - 1) begin
                ovf_sel = sel ? s1_ctrl.ovf1 : s1_ctrl.ovf0;
            end
            sel = sel ? s1_cout1[k] : s1_cout0[k];
        end

        res   = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        case (s1_ctrl.op)
            OP_AND, OP_OR: res = s1_logic;
            OP_ADD: begin
                res   = sum_sel;
                res_c = sel;
                res_v = ovf_sel;
            end
            default: begin
                res[0] = sum_sel[NSEG-1][SEG_W-1] ^ ovf_sel;
                res_c  = sel;
                res_v  = ovf_sel;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_ctrl   <= '0;
            s1_sum0   <= '0;
            s1_sum1   <= '0;
            s1_cout0  <= '0;
            s1_cout1  <= '0;
            s1_logic  <= '0;
            out_valid <= 1'b0;
            out       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b1;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (in_valid && in_ready) begin
                s1_ctrl.op   <= Operation;
                s1_ctrl.ovf0 <= mc0_w[NSEG-1] ^ cout0_w[NSEG-1];
                s1_ctrl.ovf1 <= mc1_w[NSEG-1] ^ cout1_w[NSEG-1];
                s1_sum0      <= sum0_w;
                s1_sum1      <= sum1_w;
                s1_cout0     <= cout0_w;
                s1_cout1     <= cout1_w;
                s1_logic     <= lr0_w;
            end
            if (s2_adv) begin
                out_valid <= s1_valid;
            end
            if (s1_valid && s2_adv) begin
                out       <= res;
                carry_out <= res_c;
                overflow  <= res_v;
                zero      <= (res == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_csel_pipe.sv
// tb/tb_alu_csel_pipe.sv - bench driving 32/16, 64/16 and 8/8 instances in lockstep
module tb_alu_csel_pipe;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset, in_valid, out_ready, ainv, binv, cin;
    logic [1:0]  op;
    logic [63:0] opa, opb;

    logic        rdy32, rdy64, rdy8, ov32, ov64, ov8;
    logic [31:0] out32;
    logic [63:0] out64;
    logic [7:0]  out8;
    logic        c32, c64, c8, v32, v64, v8, z32, z64, z8;

    alu_csel_pipe #(.WIDTH(32), .SEG_W(16)) d32 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy32),
        .operandA(opa[31:0]), .operandB(opb[31:0]), .Ainvert(ainv), .Binvert(binv),
        .carry_in(cin), .Operation(op), .out_valid(ov32), .out_ready(out_ready),
        .out(out32), .carry_out(c32), .overflow(v32), .zero(z32)
    );

    alu_csel_pipe #(.WIDTH(64), .SEG_W(16)) d64 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy64),
        .operandA(opa), .operandB(opb), .Ainvert(ainv), .Binvert(binv),
        .carry_in(cin), .Operation(op), .out_valid(ov64), .out_ready(out_ready),
        .out(out64), .carry_out(c64), .overflow(v64), .zero(z64)
    );

    alu_csel_pipe #(.WIDTH(8), .SEG_W(8)) d8 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy8),
        .operandA(opa[7:0]), .operandB(opb[7:0]), .Ainvert(ainv), .Binvert(binv),
        .carry_in(cin), .Operation(op), .out_valid(ov8), .out_ready(out_ready),
        .out(out8), .carry_out(c8), .overflow(v8), .zero(z8)
    );

    typedef struct {
        logic [63:0] o;
        logic        c, v, z;
    } res_t;

    typedef struct {
        res_t e32, e64, e8;
        int   age;
        logic has_tab;
        res_t tab;
    } ent_t;

    typedef struct {
        logic [31:0] a, b;
        logic        ai, bi, ci;
        logic [1:0]  op;
        logic [31:0] o;
        logic        c, v, z;
    } vec_t;

    ent_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cmp_res(input string nm, input logic [63:0] o, input logic c, input logic v,
                           input logic z, input res_t e);
        chk64({nm, ".out"}, o, e.o);
        chk1({nm, ".carry_out"}, c, e.c);
        chk1({nm, ".overflow"}, v, e.v);
        chk1({nm, ".zero"}, z, e.z);
    endtask

    // Reference: plain w-bit two's-complement arithmetic on wide integers.
    function automatic res_t ref_alu(input int w, input logic [63:0] A, input logic [63:0] B,
                                     input logic ai, input logic bi, input logic ci,
                                     input logic [1:0] o);
        logic [64:0] mask, x, y, s;
        logic        sx, sy, ss, ovf;
        res_t        r;
        mask = (65'd1 << w) - 65'd1;
        x    = {1'b0, A} & mask;
        y    = {1'b0, B} & mask;
        if (ai) x = ~x & mask;
        if (bi) y = ~y & mask;
        s    = x + y + {64'd0, ci};
        sx   = x[w-1];
        sy   = y[w-1];
        ss   = s[w-1];
        ovf  = (sx == sy) && (ss != sx);
        r.c  = 1'b0;
        r.v  = 1'b0;
        case (o)
            2'b00: r.o = 64'(x & y);
            2'b01: r.o = 64'(x | y);
            2'b10: begin r.o = 64'(s & mask); r.c = s[w]; r.v = ovf; end
            default: begin r.o = {63'd0, ss ^ ovf}; r.c = s[w]; r.v = ovf; end
        endcase
        r.z = (r.o == 64'd0);
        return r;
    endfunction

    // Called on a falling edge; returns on the next falling edge.
    task automatic step(input logic iv, input logic ordy, input logic [63:0] A, input logic [63:0] B,
                        input logic ai, input logic bi, input logic ci, input logic [1:0] o,
                        input logic ht, input res_t tab);
        logic exp_rdy, exp_ov;
        ent_t e;
        in_valid  = iv;
        out_ready = ordy;
        opa = A; opb = B; ainv = ai; binv = bi; cin = ci; op = o;
        #1;
        exp_rdy = (q.size() < 2) || ordy;
        exp_ov  = (q.size() > 0) && (q[0].age >= 1);
        chk1("in_ready32", rdy32, exp_rdy);
        chk1("in_ready64", rdy64, exp_rdy);
        chk1("in_ready8", rdy8, exp_rdy);
        chk1("out_valid32", ov32, exp_ov);
        chk1("out_valid64", ov64, exp_ov);
        chk1("out_valid8", ov8, exp_ov);
        if (exp_ov) begin
            cmp_res("w32", {32'd0, out32}, c32, v32, z32, q[0].e32);
            cmp_res("w64", out64, c64, v64, z64, q[0].e64);
            cmp_res("w8", {56'd0, out8}, c8, v8, z8, q[0].e8);
            if (q[0].has_tab) cmp_res("vec32", {32'd0, out32}, c32, v32, z32, q[0].tab);
        end
        @(posedge clock);
        foreach (q[i]) q[i].age++;
        if (exp_ov && ordy) void'(q.pop_front());
        if (iv && exp_rdy) begin
            e.e32     = ref_alu(32, A, B, ai, bi, ci, o);
            e.e64     = ref_alu(64, A, B, ai, bi, ci, o);
            e.e8      = ref_alu(8, A, B, ai, bi, ci, o);
            e.age     = 0;
            e.has_tab = ht;
            e.tab     = tab;
            q.push_back(e);
        end
        @(negedge clock);
    endtask

    task automatic check_reset_state();
        res_t r0;
        r0 = '{o: 64'd0, c: 1'b0, v: 1'b0, z: 1'b1};
        chk1("rst.in_ready32", rdy32, 1'b1);
        chk1("rst.in_ready64", rdy64, 1'b1);
        chk1("rst.in_ready8", rdy8, 1'b1);
        chk1("rst.out_valid32", ov32, 1'b0);
        chk1("rst.out_valid64", ov64, 1'b0);
        chk1("rst.out_valid8", ov8, 1'b0);
        cmp_res("rst32", {32'd0, out32}, c32, v32, z32, r0);
        cmp_res("rst64", out64, c64, v64, z64, r0);
        cmp_res("rst8", {56'd0, out8}, c8, v8, z8, r0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        check_reset_state();
        q.delete();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    function automatic logic [63:0] pick();
        logic [63:0] sp[10];
        sp = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF,
               64'h8000_0000_0000_0000, 64'h0000_0000_7FFF_FFFF, 64'h0000_0000_8000_0000,
               64'h7F, 64'h80, 64'h0000_FFFF_0000_FFFF};
        if ($urandom_range(0, 2) == 0) return sp[$urandom_range(0, 9)];
        return {$urandom, $urandom};
    endfunction

    vec_t vt[10];
    res_t none, tab;

    initial begin
        none      = '{o: 64'd0, c: 1'b0, v: 1'b0, z: 1'b0};
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        opa = '0; opb = '0; ainv = 1'b0; binv = 1'b0; cin = 1'b0; op = 2'b00;

        vt[0] = '{32'h0000FFFF, 32'h00000001, 0, 0, 0, 2'b10, 32'h00010000, 0, 0, 0};
        vt[1] = '{32'h7FFFFFFF, 32'h00000001, 0, 0, 0, 2'b10, 32'h80000000, 0, 1, 0};
        vt[2] = '{32'hFFFFFFFF, 32'h00000001, 0, 0, 0, 2'b10, 32'h00000000, 1, 0, 1};
        vt[3] = '{32'h00000005, 32'h00000007, 0, 1, 1, 2'b10, 32'hFFFFFFFE, 0, 0, 0};
        vt[4] = '{32'h00000005, 32'h00000007, 0, 1, 1, 2'b11, 32'h00000001, 0, 0, 0};
        vt[5] = '{32'h80000000, 32'h00000001, 0, 1, 1, 2'b11, 32'h00000001, 1, 1, 0};
        vt[6] = '{32'hF0F0F0F0, 32'h0F0F0F0F, 1, 1, 0, 2'b00, 32'h00000000, 0, 0, 1};
        vt[7] = '{32'hF0F0F0F0, 32'h0F0F0F0F, 0, 0, 0, 2'b01, 32'hFFFFFFFF, 0, 0, 0};
        vt[8] = '{32'h00000007, 32'h00000005, 0, 1, 1, 2'b11, 32'h00000000, 1, 0, 1};
        vt[9] = '{32'h12345678, 32'h11111111, 0, 0, 0, 2'b10, 32'h23456789, 0, 0, 0};

        @(negedge clock);
        check_reset_state();
        reset = 1'b0;

        foreach (vt[i]) begin
            tab = '{o: {32'd0, vt[i].o}, c: vt[i].c, v: vt[i].v, z: vt[i].z};
            step(1'b1, 1'b1, {32'd0, vt[i].a}, {32'd0, vt[i].b}, vt[i].ai, vt[i].bi, vt[i].ci,
                 vt[i].op, 1'b1, tab);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, '0, '0, 0, 0, 0, 2'b00, 1'b0, none);

        // Backpressure: three offers with the sink stalled, held, then released.
        step(1'b1, 1'b0, 64'h11, 64'h22, 0, 0, 0, 2'b10, 1'b0, none);
        step(1'b1, 1'b0, 64'h33, 64'h44, 0, 0, 0, 2'b10, 1'b0, none);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 64'h55, 64'h66, 0, 1, 1, 2'b10, 1'b0, none);
        step(1'b1, 1'b1, 64'h55, 64'h66, 0, 1, 1, 2'b10, 1'b0, none);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, '0, '0, 0, 0, 0, 2'b00, 1'b0, none);

        // Reset with both stages occupied, then a single op's latency.
        step(1'b1, 1'b0, 64'h7, 64'h9, 0, 0, 0, 2'b10, 1'b0, none);
        step(1'b1, 1'b0, 64'h8, 64'hA, 0, 0, 0, 2'b01, 1'b0, none);
        do_reset();
        step(1'b1, 1'b1, 64'h0000FFFF, 64'h1, 0, 0, 0, 2'b10, 1'b0, none);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, '0, '0, 0, 0, 0, 2'b00, 1'b0, none);

        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, pick(), pick(),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), 1'b0, none);
            if (i == 400) do_reset();
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, '0, '0, 0, 0, 0, 2'b00, 1'b0, none);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
